// File: rtl/residual_add_unit.sv
// Residual combine stage: element-wise main + shortcut, per-channel requantising
// shift, optional post-add activation and saturation, LANES elements per cycle.
module residual_add_unit #(
  parameter int DATA_WIDTH  = 8,
  parameter int CHANNELS    = 4,
  parameter int HEIGHT      = 4,
  parameter int WIDTH       = 4,
  parameter int LANES       = 2,
  parameter int SHIFT_WIDTH = 3,
  parameter int ACT_MODE    = 1,
  parameter int LEAKY_SHIFT = 3,
  parameter int SATURATE    = 1,
  localparam int N          = CHANNELS * HEIGHT * WIDTH,
  localparam int CW         = $clog2(N + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  output logic                          done,
  output logic                          busy,
  input  logic                          shortcut_en,
  input  logic [DATA_WIDTH*N-1:0]       main_tensor_flat,
  input  logic [DATA_WIDTH*N-1:0]       shortcut_tensor_flat,
  input  logic [CHANNELS*SHIFT_WIDTH-1:0] shift_flat,
  output logic [DATA_WIDTH*N-1:0]       output_tensor_flat,
  output logic [CW-1:0]                 sat_count
);

  localparam int HW = HEIGHT * WIDTH;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int AW = DATA_WIDTH + 2;
  localparam logic signed [AW-1:0] MAX_V = (AW'(1) <<< (DATA_WIDTH - 1)) - AW'(1);
  localparam logic signed [AW-1:0] MIN_V = -MAX_V - AW'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                        state_q, state_d;
  logic                          pend_q, pend_d;
  logic [IW-1:0]                 idx_q, idx_d;
  logic [CW-1:0]                 sat_q, sat_d;
  logic [DATA_WIDTH*N-1:0]       out_q, out_d;
  logic [DATA_WIDTH*N-1:0]       main_q, main_d;
  logic [DATA_WIDTH*N-1:0]       sc_q, sc_d;
  logic [CHANNELS*SHIFT_WIDTH-1:0] shift_q, shift_d;
  logic                          en_q, en_d;

  logic [IW-1:0]                 lane_idx [LANES];
  logic [DATA_WIDTH-1:0]         lane_res [LANES];
  logic                          lane_ovf [LANES];

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    localparam logic [IW-1:0] LANE_OFF = IW'(gi);
    logic [IW-1:0]          ch;
    logic [DATA_WIDTH-1:0]  m_el, s_el;
    logic [SHIFT_WIDTH-1:0] sh;
    logic signed [AW-1:0]   s, q, a;

    assign lane_idx[gi] = idx_q + LANE_OFF;
    assign ch   = lane_idx[gi] / IW'(HW);
    assign m_el = main_q[lane_idx[gi]*DATA_WIDTH +: DATA_WIDTH];
    assign s_el = sc_q[lane_idx[gi]*DATA_WIDTH +: DATA_WIDTH];
    assign sh   = shift_q[ch*SHIFT_WIDTH +: SHIFT_WIDTH];

    always_comb begin
      s = {{2{m_el[DATA_WIDTH-1]}}, m_el}
        + (en_q ? {{2{s_el[DATA_WIDTH-1]}}, s_el} : AW'(0));
      q = s >>> sh;
      a = q;
      if (ACT_MODE == 1) begin
        if (q < 0) a = '0;
      end else if (ACT_MODE == 2) begin
        if (q < 0) a = q >>> LEAKY_SHIFT;
      end
      lane_ovf[gi] = (a > MAX_V) || (a < MIN_V);
      lane_res[gi] = a[DATA_WIDTH-1:0];
      if (SATURATE != 0) begin
        if (a > MAX_V)      lane_res[gi] = MAX_V[DATA_WIDTH-1:0];
        else if (a < MIN_V) lane_res[gi] = MIN_V[DATA_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    idx_d   = idx_q;
    sat_d   = sat_q;
    out_d   = out_q;
    main_d  = main_q;
    sc_d    = sc_q;
    shift_d = shift_q;
    en_d    = en_q;
    case (state_q)
      S_IDLE: begin
        // Inputs are captured on the start edge; RUN begins one cycle later.
        if (pend_q) begin
          pend_d  = 1'b0;
          state_d = S_RUN;
        end else if (start) begin
          main_d  = main_tensor_flat;
          sc_d    = shortcut_tensor_flat;
          shift_d = shift_flat;
          en_d    = shortcut_en;
          sat_d   = '0;
          idx_d   = '0;
          pend_d  = 1'b1;
        end
      end
      S_RUN: begin
        for (int l = 0; l < LANES; l++) begin
          out_d[lane_idx[l]*DATA_WIDTH +: DATA_WIDTH] = lane_res[l];
          sat_d = sat_d + CW'(lane_ovf[l]);
        end
        idx_d = idx_q + IW'(LANES);
        if (idx_q == IW'(N - LANES)) begin
          idx_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (!start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pend_q  <= 1'b0;
      idx_q   <= '0;
      sat_q   <= '0;
      out_q   <= '0;
      main_q  <= '0;
      sc_q    <= '0;
      shift_q <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      idx_q   <= idx_d;
      sat_q   <= sat_d;
      out_q   <= out_d;
      main_q  <= main_d;
      sc_q    <= sc_d;
      shift_q <= shift_d;
      en_q    <= en_d;
    end
  end

  assign busy               = (state_q == S_RUN);
  assign done               = (state_q == S_DONE);
  assign output_tensor_flat = out_q;
  assign sat_count          = sat_q;

endmodule

// File: tb/tb_residual_add_unit.sv
// Directed bench for residual_add_unit: three instances (ReLU+sat, leaky+sat,
// no activation+wrap) share one stimulus stream and are checked against hand values.
module tb_residual_add_unit;

  localparam int DW = 8;
  localparam int N  = 64;
  localparam int FW = DW * N;

  logic          clk = 1'b0;
  logic          rst, start, sc_en;
  logic [FW-1:0] main_f, sc_f;
  logic [11:0]   shift_f;

  logic          done_r, busy_r, done_l, busy_l, done_n, busy_n;
  logic [FW-1:0] out_r, out_l, out_n;
  logic [6:0]    sat_r, sat_l, sat_n;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  residual_add_unit #(.ACT_MODE(1), .SATURATE(1)) u_relu (
    .clk(clk), .rst(rst), .start(start), .done(done_r), .busy(busy_r),
    .shortcut_en(sc_en), .main_tensor_flat(main_f), .shortcut_tensor_flat(sc_f),
    .shift_flat(shift_f), .output_tensor_flat(out_r), .sat_count(sat_r));

  residual_add_unit #(.ACT_MODE(2), .SATURATE(1)) u_leaky (
    .clk(clk), .rst(rst), .start(start), .done(done_l), .busy(busy_l),
    .shortcut_en(sc_en), .main_tensor_flat(main_f), .shortcut_tensor_flat(sc_f),
    .shift_flat(shift_f), .output_tensor_flat(out_l), .sat_count(sat_l));

  residual_add_unit #(.ACT_MODE(0), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .start(start), .done(done_n), .busy(busy_n),
    .shortcut_en(sc_en), .main_tensor_flat(main_f), .shortcut_tensor_flat(sc_f),
    .shift_flat(shift_f), .output_tensor_flat(out_n), .sat_count(sat_n));

  task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] fill4(input int c0, input int c1, input int c2, input int c3);
    logic [FW-1:0] r;
    int v;
    r = '0;
    for (int e = 0; e < N; e++) begin
      case (e / 16)
        0:       v = c0;
        1:       v = c1;
        2:       v = c2;
        default: v = c3;
      endcase
      r[e*DW +: DW] = 8'(v);
    end
    return r;
  endfunction

  function automatic logic [FW-1:0] fill(input int v);
    return fill4(v, v, v, v);
  endfunction

  // Start (held), scramble inputs after the start edge, then time busy/done.
  task automatic do_run(input string tag, input bit pulse);
    int cyc, bcy, both;
    bit seen;
    start = 1'b1;
    @(posedge clk); #1;
    main_f  = {16{32'hDEADBEEF}};
    sc_f    = ~main_f;
    shift_f = 12'hFFF;
    sc_en   = ~sc_en;
    cyc = 0; bcy = 0; both = 0; seen = 1'b0;
    while (!seen && cyc < 100) begin
      if (pulse && cyc == 5) start = 1'b0;
      if (pulse && cyc == 6) start = 1'b1;
      @(posedge clk); #1;
      cyc++;
      if (busy_r) bcy++;
      if (busy_r && done_r) both++;
      if (done_r) seen = 1'b1;
    end
    chk({tag, " latency"}, FW'(cyc), FW'(33));
    chk({tag, " busy_cycles"}, FW'(bcy), FW'(32));
    chk({tag, " busy_done_overlap"}, FW'(both), FW'(0));
    chk({tag, " done_leaky"}, FW'(done_l), FW'(1));
    chk({tag, " done_wrap"}, FW'(done_n), FW'(1));
  endtask

  task automatic drop_start(input string tag);
    start = 1'b0;
    @(posedge clk); #1;
    chk({tag, " done_fall"}, FW'(done_r), FW'(0));
  endtask

  initial begin
    int w;
    rst = 1'b1; start = 1'b0; sc_en = 1'b1;
    main_f = '0; sc_f = '0; shift_f = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset out", out_r, '0);
    chk("reset sat", FW'(sat_r), '0);
    chk("reset done", FW'(done_r), '0);
    chk("reset busy", FW'(busy_r), '0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Saturation / wrap on overflow
    main_f = fill(100); sc_f = fill(100); shift_f = 12'd0; sc_en = 1'b1;
    do_run("v1", 1'b0);
    chk("v1 out_relu", out_r, fill(127));
    chk("v1 sat_relu", FW'(sat_r), FW'(64));
    chk("v1 out_leaky", out_l, fill(127));
    chk("v1 out_wrap", out_n, fill(-56));
    chk("v1 sat_wrap", FW'(sat_n), FW'(64));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("hold done", FW'(done_r), FW'(1));
      chk("hold busy", FW'(busy_r), FW'(0));
    end
    drop_start("v1");
    chk("v1 retain out", out_r, fill(127));
    chk("v1 retain sat", FW'(sat_r), FW'(64));

    // Negative sums, shift 1, start glitch during RUN
    main_f = fill(-50); sc_f = fill(-30); shift_f = {4{3'd1}}; sc_en = 1'b1;
    do_run("v2", 1'b1);
    chk("v2 out_relu", out_r, fill(0));
    chk("v2 sat_relu", FW'(sat_r), FW'(0));
    chk("v2 out_leaky", out_l, fill(-5));
    chk("v2 out_wrap", out_n, fill(-40));
    drop_start("v2");

    // Per-channel shift amounts
    main_f = fill(60); sc_f = fill(4); shift_f = {3'd3, 3'd2, 3'd1, 3'd0}; sc_en = 1'b1;
    do_run("v3", 1'b0);
    chk("v3 out_relu", out_r, fill4(64, 32, 16, 8));
    chk("v3 out_leaky", out_l, fill4(64, 32, 16, 8));
    chk("v3 out_wrap", out_n, fill4(64, 32, 16, 8));
    chk("v3 sat_relu", FW'(sat_r), FW'(0));
    drop_start("v3");

    // Shortcut disabled, most negative main
    main_f = fill(-128); sc_f = fill(100); shift_f = 12'd0; sc_en = 1'b0;
    do_run("v4", 1'b0);
    chk("v4 out_wrap", out_n, fill(-128));
    chk("v4 sat_wrap", FW'(sat_n), FW'(0));
    chk("v4 out_relu", out_r, fill(0));
    chk("v4 out_leaky", out_l, fill(-16));
    drop_start("v4");

    // Reset in the middle of a run
    main_f = fill(100); sc_f = fill(100); shift_f = 12'd0; sc_en = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    w = 0;
    while (!busy_r && w < 10) begin
      @(posedge clk); #1;
      w++;
    end
    chk("rst busy_reached", FW'(busy_r), FW'(1));
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    chk("rst done", FW'(done_r), '0);
    chk("rst busy", FW'(busy_r), '0);
    chk("rst out", out_r, '0);
    chk("rst sat", FW'(sat_r), '0);
    chk("rst out_wrap", out_n, '0);
    rst = 1'b0;
    @(posedge clk); #1;

    main_f = fill(60); sc_f = fill(4); shift_f = {3'd3, 3'd2, 3'd1, 3'd0}; sc_en = 1'b1;
    do_run("post_rst", 1'b0);
    chk("post_rst out", out_r, fill4(64, 32, 16, 8));
    chk("post_rst sat", FW'(sat_r), FW'(0));
    drop_start("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
